lsu_agu: RTL
============

LSU_AGU -- requirements
Module: lsu_agu

Interface
REQ-001 Ports SHALL be exactly these; one clock, reset synchronous and active-high:
  clock  in  1  sole clock, rising edge
  reset  in  1  synchronous active-high reset
  in_valid  in  1  issued load/store from the memory issue stage
  in_ready  out  1  stage can accept this cycle
  in_src1 / in_src2  in  64 / 64  base register value / store data value
  in_imm  in  64  sign-extended offset
  in_is_store  in  1  1 = store, 0 = load
  in_size  in  4  one-hot: 0001=1B, 0010=2B, 0100=4B, 1000=8B
  in_is_unsigned  in  1  load zero-extend flag
  in_prd / in_robid / in_sqid  in  `PREG_RANGE / ROB_SIZE_LOG+1 / SQ_SIZE_LOG+1  destination, ROB id, SQ id
  flush_valid / flush_robid  in  1 / ROB_SIZE_LOG+1  kill entries strictly younger than flush_robid
  out_valid  out  1  access ready for load pipe / store queue
  out_ready  in  1  consumer accepts
  out_vaddr  out  64  virtual address
  out_mask  out  8  byte-lane enable within the aligned doubleword
  out_wdata  out  64  store data shifted to lane
  out_misalign  out  1  address not naturally aligned, or illegal size
  out_is_store, out_size, out_is_unsigned, out_prd, out_robid, out_sqid  out  as inputs  registered copies

Function
REQ-002 Two-stage pipeline S1/S2 SHALL be used, each with a valid bit; throughput 1/cycle, no bubbles.
REQ-003 Accept on in_valid && in_ready; S1 SHALL capture vaddr = in_src1 + in_imm (mod 2^64) plus all control fields.
REQ-004 S2 SHALL load from S1 when s1_valid && (!s2_valid || out_ready); S1 empties or refills the same cycle.
REQ-005 in_ready SHALL equal !reset && (!s1_valid || S1 advances this cycle); combinational path from out_ready permitted.
REQ-006 S2 SHALL compute off = vaddr[2:0], out_mask = (size mask 0x01/0x03/0x0F/0xFF << off) truncated to 8 bits, out_wdata = in_src2 << 8*off truncated to 64 bits.
REQ-007 out_misalign SHALL be 1 when vaddr mod size-bytes != 0; non-one-hot in_size SHALL give out_mask=0, out_misalign=1.
REQ-008 Accept-to-out_valid latency SHALL be 2 cycles with no backpressure; out_valid and all payloads SHALL stay stable until out_ready.
REQ-009 Age compare: a younger than b iff (wrap bits differ ? a.idx < b.idx : a.idx > b.idx); wrap bit is bit ROB_SIZE_LOG.
REQ-010 On flush_valid, same cycle: younger S1/S2 entries SHALL be invalidated, younger in_valid SHALL not be captured; equal or older SHALL survive.
REQ-011 out_valid SHALL be masked combinationally when S2 is being flushed that cycle; no handshake on a killed entry.
REQ-012 Flush with simultaneous out_ready SHALL still kill younger S2; older S2 completes normally.

Reset
REQ-013 While reset high: s1_valid=s2_valid=0, out_valid=0, in_ready=0, all payload registers 0, PMU counters 0; reset mid-transfer SHALL drop in-flight entries silently.

Configuration
REQ-014 Macro LSU_AGU_PMU_EN defined: add outputs agu_pmu_stall_cnt[31:0] (+1 each cycle s2_valid && !out_ready) and agu_pmu_flush_kill_cnt[31:0] (+1 per flush cycle killing >=1 entry), both wrapping at 2^32; undefined: ports and logic absent, remaining behaviour identical.

Verification
REQ-015 src1=0x1000, imm=-4, size=0100 load, out_ready=1 -> 2 cycles later out_vaddr=0xFFC, out_mask=0xF0, out_misalign=0.
REQ-016 Store src1=0x1005, imm=0, size=0001, src2=0xAB -> out_mask=0x20, out_wdata=0x0000_AB00_0000_0000, misalign=0.
REQ-017 Load src1=0x1003, imm=0, size=0010 -> out_mask=0x18, out_misalign=1; size=0011 -> mask=0, misalign=1.
REQ-018 out_ready=0 for 5 cycles with 3 back-to-back issues -> third stalls (in_ready=0), all 3 emerge in order, payload stable; PMU build: stall_cnt=5.
REQ-019 ROB_SIZE_LOG=6, S2 robid {1,5}, S1 robid {0,61}, flush_robid {0,60} -> both killed, out_valid=0 that cycle; robid {0,60} survives.
REQ-020 Reset asserted with S1 and S2 full -> next cycle out_valid=0, in_ready=0; after release in_ready=1, no stale output.

Source files
------------

// File: rtl/lsu_agu.sv
// lsu_agu: two-stage address generation for the load/store unit.
//   S1 registers vaddr = src1 + imm and the control fields of an issued access.
//   S2 registers the byte-lane mask, lane-shifted store data and misalignment flag.
// The optional performance counters are built only when LSU_AGU_PMU_EN is defined.
module lsu_agu #(
    parameter int DATA_W       = 64,
    parameter int ROB_SIZE_LOG = 6,
    parameter int SQ_SIZE_LOG  = 4,
    parameter int PREG_W       = 7
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_src1,
    input  logic [DATA_W-1:0]       in_src2,
    input  logic [DATA_W-1:0]       in_imm,
    input  logic                    in_is_store,
    input  logic [3:0]              in_size,
    input  logic                    in_is_unsigned,
    input  logic [PREG_W-1:0]       in_prd,
    input  logic [ROB_SIZE_LOG:0]   in_robid,
    input  logic [SQ_SIZE_LOG:0]    in_sqid,
    input  logic                    flush_valid,
    input  logic [ROB_SIZE_LOG:0]   flush_robid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_vaddr,
    output logic [7:0]              out_mask,
    output logic [DATA_W-1:0]       out_wdata,
    output logic                    out_misalign,
    output logic                    out_is_store,
    output logic [3:0]              out_size,
    output logic                    out_is_unsigned,
    output logic [PREG_W-1:0]       out_prd,
    output logic [ROB_SIZE_LOG:0]   out_robid,
    output logic [SQ_SIZE_LOG:0]    out_sqid
`ifdef LSU_AGU_PMU_EN
    ,
    output logic [31:0]             agu_pmu_stall_cnt,
    output logic [31:0]             agu_pmu_flush_kill_cnt
`endif
);

    // a is younger than b; the top bit of a ROB id is the wrap bit
    function automatic logic is_younger(input logic [ROB_SIZE_LOG:0] a,
                                        input logic [ROB_SIZE_LOG:0] b);
        if (a[ROB_SIZE_LOG] != b[ROB_SIZE_LOG])
            return a[ROB_SIZE_LOG-1:0] < b[ROB_SIZE_LOG-1:0];
        else
            return a[ROB_SIZE_LOG-1:0] > b[ROB_SIZE_LOG-1:0];
    endfunction

    // Byte lanes touched inside the aligned doubleword; illegal sizes touch nothing
    function automatic logic [7:0] lane_mask(input logic [3:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            4'b0001: base = 8'h01;
            4'b0010: base = 8'h03;
            4'b0100: base = 8'h0F;
            4'b1000: base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    // Natural alignment check; an illegal size is always reported as misaligned
    function automatic logic misaligned(input logic [3:0] size, input logic [2:0] off);
        case (size)
            4'b0001: return 1'b0;
            4'b0010: return off[0];
            4'b0100: return |off[1:0];
            4'b1000: return |off;
            default: return 1'b1;
        endcase
    endfunction

    logic                  vld_p1;
    logic [DATA_W-1:0]     vaddr_p1;
    logic [DATA_W-1:0]     src2_p1;
    logic                  is_store_p1;
    logic [3:0]            size_p1;
    logic                  uns_p1;
    logic [PREG_W-1:0]     prd_p1;
    logic [ROB_SIZE_LOG:0] robid_p1;
    logic [SQ_SIZE_LOG:0]  sqid_p1;

    logic                  vld_p2;
    logic [DATA_W-1:0]     vaddr_p2;
    logic [7:0]            mask_p2;
    logic [DATA_W-1:0]     wdata_p2;
    logic                  mis_p2;
    logic                  is_store_p2;
    logic [3:0]            size_p2;
    logic                  uns_p2;
    logic [PREG_W-1:0]     prd_p2;
    logic [ROB_SIZE_LOG:0] robid_p2;
    logic [SQ_SIZE_LOG:0]  sqid_p2;

    logic       kill_p1;
    logic       kill_p2;
    logic       kill_in;
    logic       adv_p1;
    logic       acc_p0;
    logic       fire_p2;
    logic [2:0] off_p1;

    assign kill_p1 = flush_valid && vld_p1 && is_younger(robid_p1, flush_robid);
    assign kill_p2 = flush_valid && vld_p2 && is_younger(robid_p2, flush_robid);
    assign kill_in = flush_valid && is_younger(in_robid, flush_robid);

    // S1 moves forward whenever S2 is empty or draining; a killed S2 still counts as occupied
    assign adv_p1   = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready = !reset && (!vld_p1 || adv_p1);
    assign acc_p0   = in_valid && in_ready && !kill_in;

    // A killed S2 entry is hidden the same cycle so no handshake can complete on it
    assign out_valid = vld_p2 && !kill_p2 && !reset;
    assign fire_p2   = out_valid && out_ready;
    assign off_p1    = vaddr_p1[2:0];

    // ---- S0 -> S1: capture effective address and control fields ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            vaddr_p1    <= '0;
            src2_p1     <= '0;
            is_store_p1 <= 1'b0;
            size_p1     <= '0;
            uns_p1      <= 1'b0;
            prd_p1      <= '0;
            robid_p1    <= '0;
            sqid_p1     <= '0;
        end else if (acc_p0) begin
            vld_p1      <= 1'b1;
            vaddr_p1    <= in_src1 + in_imm;
            src2_p1     <= in_src2;
            is_store_p1 <= in_is_store;
            size_p1     <= in_size;
            uns_p1      <= in_is_unsigned;
            prd_p1      <= in_prd;
            robid_p1    <= in_robid;
            sqid_p1     <= in_sqid;
        end else if (adv_p1 || kill_p1) begin
            vld_p1      <= 1'b0;
        end
    end

    // ---- S1 -> S2: lane mask, lane-shifted store data, alignment ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2      <= 1'b0;
            vaddr_p2    <= '0;
            mask_p2     <= '0;
            wdata_p2    <= '0;
            mis_p2      <= 1'b0;
            is_store_p2 <= 1'b0;
            size_p2     <= '0;
            uns_p2      <= 1'b0;
            prd_p2      <= '0;
            robid_p2    <= '0;
            sqid_p2     <= '0;
        end else if (adv_p1) begin
            vld_p2      <= !kill_p1;
            vaddr_p2    <= vaddr_p1;
            mask_p2     <= lane_mask(size_p1, off_p1);
            wdata_p2    <= src2_p1 << {off_p1, 3'b000};
            mis_p2      <= misaligned(size_p1, off_p1);
            is_store_p2 <= is_store_p1;
            size_p2     <= size_p1;
            uns_p2      <= uns_p1;
            prd_p2      <= prd_p1;
            robid_p2    <= robid_p1;
            sqid_p2     <= sqid_p1;
        end else if (fire_p2 || kill_p2) begin
            vld_p2      <= 1'b0;
        end
    end

    assign out_vaddr       = vaddr_p2;
    assign out_mask        = mask_p2;
    assign out_wdata       = wdata_p2;
    assign out_misalign    = mis_p2;
    assign out_is_store    = is_store_p2;
    assign out_size        = size_p2;
    assign out_is_unsigned = uns_p2;
    assign out_prd         = prd_p2;
    assign out_robid       = robid_p2;
    assign out_sqid        = sqid_p2;

`ifdef LSU_AGU_PMU_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] kill_cnt_q;

    // Count backpressure cycles and flush cycles that removed at least one entry
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            if (vld_p2 && !out_ready)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (kill_p1 || kill_p2)
                kill_cnt_q <= kill_cnt_q + 32'd1;
        end
    end

    assign agu_pmu_stall_cnt      = stall_cnt_q;
    assign agu_pmu_flush_kill_cnt = kill_cnt_q;
`else
    // Performance counters not built in this configuration
`endif

endmodule
